// File: rtl/ppm_accum.sv
// Final adder and MAC stage: resolves the multiplier's sum/carry pair
// and loads, adds or subtracts the signed product into a wide accumulator.
module ppm_accum #(
    parameter int PW    = 34,
    parameter int ACC_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW:0]      in_sum,
    input  logic [PW:0]      in_carry,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    logic                    s1_valid;
    logic [PW-1:0]           s1_sum;
    logic [PW-1:0]           s1_carry;
    logic [1:0]              s1_mode;
    logic                    s2_adv;
    logic signed [PW-1:0]    prod;
    logic [ACC_W-1:0]        prod_ext;
    logic [ACC_W-1:0]        acc_q;
    logic                    ovf_q;
    logic [ACC_W-1:0]        acc_nxt;
    logic                    ovf_nxt;
    logic                    unused_top;

    // Bit PW of each redundant vector is a multiplier artefact.
    assign unused_top = in_sum[PW] ^ in_carry[PW];

    assign s2_adv    = s1_valid && (!out_valid || out_ready);
    assign in_ready  = !s1_valid || s2_adv;
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;

    assign prod     = signed'(s1_sum + s1_carry);
    assign prod_ext = ACC_W'(prod);

    always_comb begin
        acc_nxt = '0;
        ovf_nxt = 1'b0;
        unique case (s1_mode)
            2'b00: acc_nxt = prod_ext;
            2'b01: begin
                acc_nxt = acc_q + prod_ext;
                ovf_nxt = (acc_q[ACC_W-1] == prod_ext[ACC_W-1])
                       && (acc_nxt[ACC_W-1] != acc_q[ACC_W-1]);
            end
            2'b10: begin
                acc_nxt = acc_q - prod_ext;
                ovf_nxt = (acc_q[ACC_W-1] != prod_ext[ACC_W-1])
                       && (acc_nxt[ACC_W-1] != acc_q[ACC_W-1]);
            end
            2'b11: acc_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_carry <= '0;
            s1_mode  <= 2'b00;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_sum   <= in_sum[PW-1:0];
            s1_carry <= in_carry[PW-1:0];
            s1_mode  <= in_mode;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= 1'b1;
            acc_q     <= acc_nxt;
            ovf_q     <= ovf_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ppm_accum.sv
// Directed bench for ppm_accum: a 48-bit and a 36-bit instance share
// every input; outputs are collected per handshake and compared.
module tb_ppm_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [34:0] in_sum;
    logic [34:0] in_carry;
    logic [1:0]  in_mode;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_ovf;
    logic [47:0] a_data;
    logic        b_in_ready, b_out_valid, b_ovf;
    logic [35:0] b_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit hit;

    logic [63:0] qa[$];
    logic        qao[$];
    logic [63:0] qb[$];
    logic        qbo[$];
    int          qcyc[$];
    int          acyc[$];

    always #5 clk = ~clk;

    ppm_accum #(.PW(34), .ACC_W(48)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .in_mode(in_mode),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_data), .out_ovf(a_ovf)
    );

    ppm_accum #(.PW(34), .ACC_W(36)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .in_mode(in_mode),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_data), .out_ovf(b_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        hit = in_valid && a_in_ready;
        if (hit) acyc.push_back(cyc);
        if (a_out_valid && out_ready) begin
            qa.push_back(64'(a_data));
            qao.push_back(a_ovf);
            qb.push_back(64'(b_data));
            qbo.push_back(b_ovf);
            qcyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [34:0] s, input logic [34:0] c,
                        input logic [1:0] m);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_sum = s;
        in_carry = c;
        in_mode = m;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            done = hit;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (6) tick();
    endtask

    task automatic clr();
        qa.delete(); qao.delete(); qb.delete(); qbo.delete();
        qcyc.delete(); acyc.delete();
    endtask

    logic [63:0] hold;
    int          nacc;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_sum = '0;
        in_carry = '0;
        in_mode = 2'b00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_data", 64'(a_data), 64'd0);
        chk("rst_out_ovf", 64'(a_ovf), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);

        // Wrap with garbage bit 34, then a negative product
        clr();
        send(35'h7_FFFF_FFFF, 35'h10, 2'b00);
        send(35'h3_FFFF_FFF0, 35'h1, 2'b00);
        drain();
        chk("wrap_n", 64'(qa.size()), 64'd2);
        chk("wrap_data", qa[0], 64'h0000_0000_000F);
        chk("wrap_ovf", 64'(qao[0]), 64'd0);
        chk("neg_data", qa[1], 64'hFFFF_FFFF_FFF1);
        chk("neg_ovf", 64'(qao[1]), 64'd0);

        // MAC at full rate
        clr();
        send(35'd15, 35'd0, 2'b00);
        send(35'd7, 35'd0, 2'b01);
        send(35'd2, 35'd0, 2'b10);
        send(35'd0, 35'd0, 2'b11);
        drain();
        chk("mac_n", 64'(qa.size()), 64'd4);
        chk("mac0", qa[0], 64'd15);
        chk("mac1", qa[1], 64'd22);
        chk("mac2", qa[2], 64'd20);
        chk("mac3", qa[3], 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mac_ovf%0d", i), 64'(qao[i]), 64'd0);
            chk($sformatf("mac_cyc%0d", i), 64'(qcyc[i]),
                64'(acyc[0] + 2 + i));
        end

        // Overflow on the 36-bit instance, add then subtract
        clr();
        send(35'h1_FFFF_FFFF, 35'd0, 2'b00);
        repeat (4) send(35'h1_FFFF_FFFF, 35'd0, 2'b01);
        send(35'h1_FFFF_FFFF, 35'd0, 2'b10);
        drain();
        chk("ovf_n", 64'(qb.size()), 64'd6);
        chk("ovf_b0", qb[0], 64'h1_FFFF_FFFF);
        chk("ovf_b3", qb[3], 64'h7_FFFF_FFFC);
        chk("ovf_b3_flag", 64'(qbo[3]), 64'd0);
        chk("ovf_b4", qb[4], 64'h9_FFFF_FFFB);
        chk("ovf_b4_flag", 64'(qbo[4]), 64'd1);
        chk("ovf_b5_sub", qb[5], 64'h7_FFFF_FFFC);
        chk("ovf_b5_flag", 64'(qbo[5]), 64'd1);
        chk("ovf_a4", qa[4], 64'h9_FFFF_FFFB);
        chk("ovf_a4_flag", 64'(qao[4]), 64'd0);
        chk("ovf_a5_flag", 64'(qao[5]), 64'd0);

        // Backpressure
        clr();
        out_ready = 1'b0;
        nacc = 0;
        in_valid = 1'b1;
        in_sum = 35'd100;
        in_carry = '0;
        in_mode = 2'b00;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) hold = 64'(a_data);
            tick();
            if (hit) begin
                nacc++;
                in_sum = (nacc == 1) ? 35'd1 : 35'd2;
                in_mode = 2'b01;
            end
        end
        chk("bp_accepted", 64'(nacc), 64'd2);
        chk("bp_in_ready", 64'(a_in_ready), 64'd0);
        chk("bp_valid", 64'(a_out_valid), 64'd1);
        chk("bp_stable", 64'(a_data), hold);
        chk("bp_hold_val", hold, 64'd100);
        out_ready = 1'b1;
        send(35'd2, 35'd0, 2'b01);
        drain();
        chk("bp_n", 64'(qa.size()), 64'd3);
        chk("bp0", qa[0], 64'd100);
        chk("bp1", qa[1], 64'd101);
        chk("bp2", qa[2], 64'd103);

        // Async reset with both stages full
        clr();
        out_ready = 1'b0;
        send(35'd9, 35'd0, 2'b00);
        send(35'd4, 35'd0, 2'b01);
        in_valid = 1'b0;
        chk("ar_pre_valid", 64'(a_out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(a_out_valid), 64'd0);
        chk("ar_data", 64'(a_data), 64'd0);
        chk("ar_in_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        clr();
        send(35'd5, 35'd0, 2'b01);
        drain();
        chk("ar_n", 64'(qa.size()), 64'd1);
        chk("ar_post", qa[0], 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
